// File: rtl/pipeline_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_sequencer
// Purpose  : CPU pipeline-advance strobe generator (free-run/step/burst/halt)
//            plus regfile port scheduler and debug scan address counter.
// Revision : 1.0  initial release
// ============================================================================
module pipeline_sequencer #(
   parameter int DIV_W = 6,
   parameter int CNT_W = 8,
   parameter int PC_W  = 8,
   parameter int RA_W  = 4
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             PAUSE,
   input  logic             STEP,
   input  logic             BURST_GO,
   input  logic [CNT_W-1:0] BURST_LEN,
   input  logic [DIV_W-1:0] DIV,
   input  logic             BP_EN,
   input  logic [PC_W-1:0]  BP_ADDR,
   input  logic [PC_W-1:0]  PC,
   input  logic             RESUME,
   output logic             ADV,
   output logic             WB_WIN,
   output logic [1:0]       PORT_SEL,
   output logic [RA_W-1:0]  SCAN_RA,
   output logic             SCAN_VALID,
   output logic [1:0]       STATE,
   output logic [CNT_W-1:0] BURST_REM,
   output logic             HALTED
);

   typedef enum logic [1:0] {
      ST_PAUSED = 2'd0,
      ST_RUN    = 2'd1,
      ST_BURST  = 2'd2,
      ST_HALT   = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
   logic [DIV_W-1:0] div_max;
   logic [CNT_W-1:0] burst_rem_q, burst_rem_d;
   logic [RA_W-1:0]  scan_ra_q, scan_ra_d;
   logic             adv_q, adv_d;
   logic             wb_q;
   logic             step_pend_q, step_pend_d;
   logic             running, keep_running;
   logic             div_tc, bp_hit, step_ok;
   logic [1:0]       port_sel;

   // DIV=0 is treated as DIV=1 so strobes are always at least 2 CLKs apart
   assign div_max = (DIV == '0) ? DIV_W'(1) : DIV;
   assign running = (state_q == ST_RUN) || (state_q == ST_BURST);
   assign div_tc  = running && (div_cnt_q >= div_max);
   assign bp_hit  = running && wb_q && BP_EN && (PC == BP_ADDR);

   always_comb begin
      state_d      = state_q;
      burst_rem_d  = burst_rem_q;
      step_pend_d  = step_pend_q;
      div_cnt_d    = div_cnt_q;
      adv_d        = 1'b0;
      step_ok      = 1'b0;
      keep_running = 1'b0;

      case (state_q)
         ST_PAUSED: begin
            if (!PAUSE) begin
               state_d = ST_RUN;
            end else if (BURST_GO && (BURST_LEN != '0)) begin
               state_d     = ST_BURST;
               burst_rem_d = BURST_LEN;
            end else begin
               step_ok = STEP;
            end
         end
         ST_RUN: begin
            if (bp_hit) begin
               state_d = ST_HALT;
            end else if (PAUSE) begin
               state_d = ST_PAUSED;
            end
         end
         ST_BURST: begin
            if (div_tc) begin
               burst_rem_d = burst_rem_q - CNT_W'(1);
            end
            if (bp_hit) begin
               state_d = ST_HALT;
            end else if (!PAUSE) begin
               state_d     = ST_RUN;
               burst_rem_d = '0;
            end else if (div_tc && (burst_rem_q == CNT_W'(1))) begin
               state_d = ST_PAUSED;
            end
         end
         default: begin
            if (RESUME) begin
               state_d     = PAUSE ? ST_PAUSED : ST_RUN;
               burst_rem_d = '0;
            end else begin
               step_ok = STEP;
            end
         end
      endcase

      keep_running = running && ((state_d == ST_RUN) || (state_d == ST_BURST));

      // A terminal count already reached is honoured even if the state moves on
      if (div_tc) begin
         adv_d     = 1'b1;
         div_cnt_d = '0;
      end else if (keep_running) begin
         div_cnt_d = div_cnt_q + DIV_W'(1);
      end else begin
         div_cnt_d = '0;
      end

      // A pending step fires right after the write window; further steps are dropped
      if (step_pend_q && wb_q) begin
         adv_d       = 1'b1;
         step_pend_d = 1'b0;
      end else if (step_ok) begin
         if (adv_q) begin
            step_pend_d = 1'b1;
         end else begin
            adv_d = 1'b1;
         end
      end
   end

   always_comb begin
      port_sel = 2'b00;
      if (wb_q) begin
         port_sel = 2'b10;
      end else if (adv_q) begin
         port_sel = 2'b01;
      end
   end

   assign scan_ra_d = (port_sel == 2'b00) ? (scan_ra_q + RA_W'(1)) : scan_ra_q;

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q     <= ST_PAUSED;
         div_cnt_q   <= '0;
         burst_rem_q <= '0;
         scan_ra_q   <= '0;
         adv_q       <= 1'b0;
         wb_q        <= 1'b0;
         step_pend_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         div_cnt_q   <= div_cnt_d;
         burst_rem_q <= burst_rem_d;
         scan_ra_q   <= scan_ra_d;
         adv_q       <= adv_d;
         wb_q        <= adv_q;
         step_pend_q <= step_pend_d;
      end
   end

   assign ADV        = adv_q;
   assign WB_WIN     = wb_q;
   assign PORT_SEL   = port_sel;
   assign SCAN_RA    = scan_ra_q;
   assign SCAN_VALID = (port_sel == 2'b00);
   assign STATE      = state_q;
   assign BURST_REM  = burst_rem_q;
   assign HALTED     = (state_q == ST_HALT);

endmodule
`default_nettype wire

// File: tb/tb_pipeline_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_sequencer
// Purpose  : Directed self-checking bench for pipeline_sequencer.
// Revision : 1.0  initial release
// ============================================================================
module tb_pipeline_sequencer;

   localparam int DIV_W = 6;
   localparam int CNT_W = 8;
   localparam int PC_W  = 8;
   localparam int RA_W  = 4;

   logic             CLK;
   logic             RST_N;
   logic             PAUSE;
   logic             STEP;
   logic             BURST_GO;
   logic [CNT_W-1:0] BURST_LEN;
   logic [DIV_W-1:0] DIV;
   logic             BP_EN;
   logic [PC_W-1:0]  BP_ADDR;
   logic [PC_W-1:0]  PC;
   logic             RESUME;
   logic             ADV;
   logic             WB_WIN;
   logic [1:0]       PORT_SEL;
   logic [RA_W-1:0]  SCAN_RA;
   logic             SCAN_VALID;
   logic [1:0]       STATE;
   logic [CNT_W-1:0] BURST_REM;
   logic             HALTED;

   int errors = 0;
   int checks = 0;

   pipeline_sequencer #(
      .DIV_W(DIV_W), .CNT_W(CNT_W), .PC_W(PC_W), .RA_W(RA_W)
   ) dut (
      .CLK(CLK), .RST_N(RST_N), .PAUSE(PAUSE), .STEP(STEP),
      .BURST_GO(BURST_GO), .BURST_LEN(BURST_LEN), .DIV(DIV),
      .BP_EN(BP_EN), .BP_ADDR(BP_ADDR), .PC(PC), .RESUME(RESUME),
      .ADV(ADV), .WB_WIN(WB_WIN), .PORT_SEL(PORT_SEL), .SCAN_RA(SCAN_RA),
      .SCAN_VALID(SCAN_VALID), .STATE(STATE), .BURST_REM(BURST_REM),
      .HALTED(HALTED)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset;
      RST_N = 1'b0; PAUSE = 1'b1; STEP = 1'b0; BURST_GO = 1'b0;
      BURST_LEN = '0; DIV = '0; BP_EN = 1'b0; BP_ADDR = '0; PC = '0; RESUME = 1'b0;
      tick();
      tick();
      RST_N = 1'b1;
   endtask

   task automatic test_reset;
      do_reset();
      checks++; if (STATE !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", STATE); end
      checks++; if (ADV !== 1'b0) begin errors++; $display("FAIL reset_adv: got %b expected 0", ADV); end
      checks++; if (WB_WIN !== 1'b0) begin errors++; $display("FAIL reset_wb: got %b expected 0", WB_WIN); end
      checks++; if (BURST_REM !== 8'd0) begin errors++; $display("FAIL reset_rem: got %0d expected 0", BURST_REM); end
      checks++; if (SCAN_RA !== 4'd0) begin errors++; $display("FAIL reset_scan_ra: got %0d expected 0", SCAN_RA); end
      checks++; if (PORT_SEL !== 2'b00) begin errors++; $display("FAIL reset_port_sel: got %b expected 00", PORT_SEL); end
      checks++; if (SCAN_VALID !== 1'b1) begin errors++; $display("FAIL reset_scan_valid: got %b expected 1", SCAN_VALID); end
      checks++; if (HALTED !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b expected 0", HALTED); end
   endtask

   task automatic test_scan_idle;
      logic [4:0] cnt;
      do_reset();
      for (int k = 1; k <= 20; k++) begin
         tick();
         cnt = 5'(k);
         checks++; if (SCAN_RA !== cnt[3:0]) begin errors++; $display("FAIL scan_idle_ra k=%0d: got %0d expected %0d", k, SCAN_RA, cnt[3:0]); end
         checks++; if (SCAN_VALID !== 1'b1) begin errors++; $display("FAIL scan_idle_valid k=%0d: got %b expected 1", k, SCAN_VALID); end
      end
   endtask

   task automatic test_run;
      logic [3:0] exp_scan;
      logic [1:0] exp_sel, prev_sel;
      logic       exp_adv, exp_wb;
      do_reset();
      exp_scan = 4'd0;
      prev_sel = 2'b00;
      PAUSE = 1'b0;
      DIV   = 6'd3;
      for (int k = 1; k <= 17; k++) begin
         tick();
         exp_adv = (k >= 5) && (((k - 5) % 4) == 0);
         exp_wb  = (k >= 6) && (((k - 6) % 4) == 0);
         exp_sel = exp_wb ? 2'b10 : (exp_adv ? 2'b01 : 2'b00);
         if (prev_sel == 2'b00) exp_scan = exp_scan + 4'd1;
         prev_sel = exp_sel;
         checks++; if (STATE !== 2'd1) begin errors++; $display("FAIL run_state k=%0d: got %0d expected 1", k, STATE); end
         checks++; if (ADV !== exp_adv) begin errors++; $display("FAIL run_adv k=%0d: got %b expected %b", k, ADV, exp_adv); end
         checks++; if (WB_WIN !== exp_wb) begin errors++; $display("FAIL run_wb k=%0d: got %b expected %b", k, WB_WIN, exp_wb); end
         checks++; if (PORT_SEL !== exp_sel) begin errors++; $display("FAIL run_port_sel k=%0d: got %b expected %b", k, PORT_SEL, exp_sel); end
         checks++; if (SCAN_RA !== exp_scan) begin errors++; $display("FAIL run_scan_ra k=%0d: got %0d expected %0d", k, SCAN_RA, exp_scan); end
         checks++; if (SCAN_VALID !== (exp_sel == 2'b00)) begin errors++; $display("FAIL run_scan_valid k=%0d: got %b", k, SCAN_VALID); end
      end
   endtask

   task automatic test_div0;
      logic exp_adv;
      do_reset();
      PAUSE = 1'b0;
      DIV   = 6'd0;
      for (int k = 1; k <= 9; k++) begin
         tick();
         exp_adv = (k >= 3) && (((k - 3) % 2) == 0);
         checks++; if (ADV !== exp_adv) begin errors++; $display("FAIL div0_adv k=%0d: got %b expected %b", k, ADV, exp_adv); end
      end
   endtask

   task automatic test_step;
      int  nadv;
      logic exp_adv, exp_wb;
      for (int np = 2; np <= 3; np++) begin
         do_reset();
         PAUSE = 1'b1;
         DIV   = 6'd0;
         nadv  = 0;
         STEP  = 1'b1;
         for (int k = 1; k <= 8; k++) begin
            tick();
            if (k >= np) STEP = 1'b0;
            exp_adv = (k == 1) || (k == 3);
            exp_wb  = (k == 2) || (k == 4);
            if (ADV === 1'b1) nadv++;
            checks++; if (ADV !== exp_adv) begin errors++; $display("FAIL step%0d_adv k=%0d: got %b expected %b", np, k, ADV, exp_adv); end
            checks++; if (WB_WIN !== exp_wb) begin errors++; $display("FAIL step%0d_wb k=%0d: got %b expected %b", np, k, WB_WIN, exp_wb); end
         end
         checks++; if (nadv != 2) begin errors++; $display("FAIL step%0d_count: got %0d expected 2", np, nadv); end
         checks++; if (STATE !== 2'd0) begin errors++; $display("FAIL step%0d_state: got %0d expected 0", np, STATE); end
      end
   endtask

   task automatic test_burst;
      logic [7:0] exp_rem;
      logic [1:0] exp_state;
      logic       exp_adv;
      do_reset();
      PAUSE     = 1'b1;
      DIV       = 6'd2;
      BURST_LEN = 8'd5;
      BURST_GO  = 1'b1;
      exp_rem   = 8'd5;
      for (int k = 1; k <= 22; k++) begin
         tick();
         BURST_GO = 1'b0;
         exp_adv = (k >= 4) && (k <= 16) && (((k - 4) % 3) == 0);
         if (exp_adv) exp_rem = exp_rem - 8'd1;
         exp_state = (exp_rem == 8'd0) ? 2'd0 : 2'd2;
         checks++; if (ADV !== exp_adv) begin errors++; $display("FAIL burst_adv k=%0d: got %b expected %b", k, ADV, exp_adv); end
         checks++; if (BURST_REM !== exp_rem) begin errors++; $display("FAIL burst_rem k=%0d: got %0d expected %0d", k, BURST_REM, exp_rem); end
         checks++; if (STATE !== exp_state) begin errors++; $display("FAIL burst_state k=%0d: got %0d expected %0d", k, STATE, exp_state); end
      end
      BURST_LEN = 8'd0;
      BURST_GO  = 1'b1;
      tick();
      BURST_GO = 1'b0;
      checks++; if (STATE !== 2'd0) begin errors++; $display("FAIL burst_len0_state: got %0d expected 0", STATE); end
      for (int k = 1; k <= 10; k++) begin
         tick();
         checks++; if (ADV !== 1'b0) begin errors++; $display("FAIL burst_len0_adv k=%0d: got %b expected 0", k, ADV); end
      end
   endtask

   task automatic test_breakpoint;
      logic [1:0] exp_state;
      do_reset();
      PAUSE   = 1'b0;
      DIV     = 6'd3;
      BP_EN   = 1'b1;
      BP_ADDR = 8'h10;
      PC      = 8'h0E;
      for (int k = 1; k <= 11; k++) begin
         tick();
         exp_state = (k >= 11) ? 2'd3 : 2'd1;
         checks++; if (ADV !== ((k == 5) || (k == 9))) begin errors++; $display("FAIL bp_adv k=%0d: got %b", k, ADV); end
         checks++; if (STATE !== exp_state) begin errors++; $display("FAIL bp_state k=%0d: got %0d expected %0d", k, STATE, exp_state); end
         if (k == 5) PC = 8'h0F;
         if (k == 9) PC = 8'h10;
      end
      for (int k = 1; k <= 50; k++) begin
         tick();
         checks++; if (ADV !== 1'b0) begin errors++; $display("FAIL bp_halt_adv k=%0d: got %b expected 0", k, ADV); end
         checks++; if (HALTED !== 1'b1) begin errors++; $display("FAIL bp_halted k=%0d: got %b expected 1", k, HALTED); end
      end
      STEP = 1'b1;
      tick();
      STEP = 1'b0;
      checks++; if (ADV !== 1'b1) begin errors++; $display("FAIL halt_step_adv: got %b expected 1", ADV); end
      tick();
      checks++; if (WB_WIN !== 1'b1) begin errors++; $display("FAIL halt_step_wb: got %b expected 1", WB_WIN); end
      checks++; if (ADV !== 1'b0) begin errors++; $display("FAIL halt_step_single: got %b expected 0", ADV); end
      tick();
      checks++; if (STATE !== 2'd3) begin errors++; $display("FAIL halt_step_state: got %0d expected 3", STATE); end
      checks++; if (ADV !== 1'b0) begin errors++; $display("FAIL halt_step_noextra: got %b expected 0", ADV); end
      PC     = 8'h11;
      RESUME = 1'b1;
      tick();
      RESUME = 1'b0;
      checks++; if (STATE !== 2'd1) begin errors++; $display("FAIL resume_state: got %0d expected 1", STATE); end
      checks++; if (HALTED !== 1'b0) begin errors++; $display("FAIL resume_halted: got %b expected 0", HALTED); end
      for (int k = 1; k <= 4; k++) begin
         tick();
         checks++; if (ADV !== (k == 4)) begin errors++; $display("FAIL resume_adv k=%0d: got %b", k, ADV); end
      end
   endtask

   task automatic test_reset_mid_burst;
      do_reset();
      PAUSE     = 1'b1;
      DIV       = 6'd2;
      BURST_LEN = 8'd5;
      BURST_GO  = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         tick();
         BURST_GO = 1'b0;
      end
      checks++; if (BURST_REM !== 8'd3) begin errors++; $display("FAIL midrst_pre_rem: got %0d expected 3", BURST_REM); end
      checks++; if (STATE !== 2'd2) begin errors++; $display("FAIL midrst_pre_state: got %0d expected 2", STATE); end
      RST_N = 1'b0;
      tick();
      checks++; if (STATE !== 2'd0) begin errors++; $display("FAIL midrst_state: got %0d expected 0", STATE); end
      checks++; if (BURST_REM !== 8'd0) begin errors++; $display("FAIL midrst_rem: got %0d expected 0", BURST_REM); end
      checks++; if (SCAN_RA !== 4'd0) begin errors++; $display("FAIL midrst_scan_ra: got %0d expected 0", SCAN_RA); end
      checks++; if (WB_WIN !== 1'b0) begin errors++; $display("FAIL midrst_wb: got %b expected 0", WB_WIN); end
      RST_N = 1'b1;
      for (int k = 1; k <= 15; k++) begin
         tick();
         checks++; if (ADV !== 1'b0) begin errors++; $display("FAIL midrst_adv k=%0d: got %b expected 0", k, ADV); end
      end
      checks++; if (STATE !== 2'd0) begin errors++; $display("FAIL midrst_post_state: got %0d expected 0", STATE); end
   endtask

   initial begin
      test_reset();
      test_scan_idle();
      test_run();
      test_div0();
      test_step();
      test_burst();
      test_breakpoint();
      test_reset_mid_burst();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
